// File: rtl/serial_link_master.sv
// serial_link_master: frames four 32-bit tx words out over a divided link clock
// (sync pulse + 32 MSB-first data pulses per slot, plus a closing sync pulse) and
// captures four 32-bit rx words returned LSB-first by the slave.
// Optional build macro SLINK_AUTORUN_EN: after the first start, frames repeat
// back-to-back. The DONE cycle then doubles as the first low cycle of the next
// frame's opening sync pulse, so done pulses are exactly one frame apart.
module serial_link_master #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic        clk_board,
   input  logic        sys_reset_n,
   input  logic        start,
   input  logic        wr_en,
   input  logic [1:0]  wr_slot,
   input  logic [31:0] wr_data,
   input  logic [1:0]  rd_slot,
   output logic [31:0] rd_data,
   output logic        busy,
   output logic        done,
   output logic        clk_data,
   output logic        data_sync_en,
   output logic        datainbit,
   input  logic        dataoutbit
);

   typedef enum logic [2:0] {StIdle, StSync, StShift, StTail, StDone} state_e;

   localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

   state_e      state_q, state_d;
   logic [7:0]  div_q, div_d;
   logic        phase_q, phase_d;   // 0: low half of a link pulse, 1: high half
   logic [4:0]  bit_q, bit_d;
   logic [1:0]  slot_q, slot_d;
   logic [31:0] shift_q, shift_d;
   logic [31:0] tx_q [4];
   logic [31:0] rx_q [4];

   logic link_run, div_wrap, rise, pulse_end, last_bit, tx_we, rx_we, sync_phase;

   // Decode which states drive the link divider and the sync qualifier
   always_comb begin
      link_run   = (state_q == StSync) || (state_q == StShift) || (state_q == StTail);
      sync_phase = (state_q == StSync) || (state_q == StTail);
`ifdef SLINK_AUTORUN_EN
      if (state_q == StDone) begin
         link_run   = 1'b1;
         sync_phase = 1'b1;
      end
`endif
   end

   assign div_wrap  = (div_q == DivLast);
   assign rise      = link_run && div_wrap && !phase_q;  // cycle that drives clk_data 0->1
   assign pulse_end = link_run && div_wrap && phase_q;   // last cycle of a high phase
   assign last_bit  = (bit_q == 5'd31);
   assign tx_we     = wr_en && (state_q == StIdle);
   assign rx_we     = (state_q == StShift) && pulse_end && last_bit;

   // FSM state register
   always_ff @(posedge clk_board or negedge sys_reset_n) begin
      if (!sys_reset_n) state_q <= StIdle;
      else              state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StSync;
         StSync:  if (pulse_end) state_d = StShift;
         StShift: if (pulse_end && last_bit) state_d = (slot_q == 2'd3) ? StTail : StSync;
         StTail:  if (pulse_end) state_d = StDone;
`ifdef SLINK_AUTORUN_EN
         StDone:  state_d = StSync;
`else
         StDone:  state_d = StIdle;
`endif
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs and rx read mux
   always_comb begin
      busy         = (state_q != StIdle);
      done         = (state_q == StDone);
      clk_data     = phase_q && ((state_q == StSync) || (state_q == StShift) ||
                                 (state_q == StTail));
      data_sync_en = sync_phase;
      datainbit    = (state_q == StShift) ? tx_q[slot_q][5'd31 - bit_q] : 1'b0;
      rd_data      = rx_q[rd_slot];
   end

   // Divider, bit/slot counters and rx shift assembly
   always_comb begin
      div_d   = 8'd0;
      phase_d = 1'b0;
      bit_d   = bit_q;
      slot_d  = slot_q;
      shift_d = shift_q;
      if (link_run) begin
         phase_d = phase_q;
         if (div_wrap) phase_d = ~phase_q;
         else          div_d   = div_q + 8'd1;
      end
      if (state_q == StIdle) begin
         bit_d  = 5'd0;
         slot_d = 2'd0;
      end else if (state_q == StShift) begin
         if (rise) shift_d[bit_q] = dataoutbit;
         if (pulse_end) begin
            bit_d = bit_q + 5'd1;
            if (last_bit) slot_d = slot_q + 2'd1;
         end
      end
   end

   // Counter and shift registers
   always_ff @(posedge clk_board or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         div_q   <= 8'd0;
         phase_q <= 1'b0;
         bit_q   <= 5'd0;
         slot_q  <= 2'd0;
         shift_q <= 32'd0;
      end else begin
         div_q   <= div_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         slot_q  <= slot_d;
         shift_q <= shift_d;
      end
   end

   // tx/rx register files; tx writable only while idle, rx committed per slot
   always_ff @(posedge clk_board or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         for (int i = 0; i < 4; i++) begin
            tx_q[i] <= 32'd0;
            rx_q[i] <= 32'd0;
         end
      end else begin
         if (tx_we) tx_q[wr_slot] <= wr_data;
         if (rx_we) rx_q[slot_q]  <= shift_q;
      end
   end

endmodule

// File: tb/tb_serial_link_master.sv
// tb_serial_link_master: frame-level model of serial_link_master. The model places
// each cycle of a frame as (pulse index, phase) and derives link outputs, slave
// response and rx contents from that; literal checks pin key values.
module tb_serial_link_master;

   localparam int DIV    = 3;
   localparam int PER    = 2 * DIV;
   localparam int FRAME  = 266 * DIV;
   localparam int DONE_K = FRAME + 1;

   logic        clk_board;
   logic        sys_reset_n, start, wr_en, dataoutbit;
   logic [1:0]  wr_slot, rd_slot;
   logic [31:0] wr_data, rd_data;
   logic        busy, done, clk_data, data_sync_en, datainbit;

   serial_link_master #(.CLK_DIV(DIV)) dut (
      .clk_board    (clk_board),
      .sys_reset_n  (sys_reset_n),
      .start        (start),
      .wr_en        (wr_en),
      .wr_slot      (wr_slot),
      .wr_data      (wr_data),
      .rd_slot      (rd_slot),
      .rd_data      (rd_data),
      .busy         (busy),
      .done         (done),
      .clk_data     (clk_data),
      .data_sync_en (data_sync_en),
      .datainbit    (datainbit),
      .dataoutbit   (dataoutbit)
   );

   initial begin
      clk_board = 1'b0;
      forever #5 clk_board = ~clk_board;
   end

   int n_tests = 0;
   int n_fail  = 0;
   int edge_cnt = 0;

   always @(posedge clk_board) edge_cnt <= edge_cnt + 1;

   // Model state: k = 1 is the first cycle after the edge that accepted start
   logic [31:0] m_tx [4];
   logic [31:0] m_base [4];
   logic [31:0] m_slave [4];
   logic [31:0] next_slave [4];
   bit          m_valid = 1'b0;
   int          m_base_edge = 0;

   function automatic int cur_k();
      return edge_cnt - m_base_edge + 1;
   endfunction

   function automatic bit m_busy(input int k);
      return m_valid && (k >= 1) && (k <= DONE_K);
   endfunction

   // {busy, done, clk_data, data_sync_en, datainbit}
   function automatic logic [4:0] m_out(input int k);
      int p, ph, s, j;
      logic [4:0] o;
      o = 5'b0;
      if (m_busy(k)) begin
         if (k == DONE_K) begin
            o = 5'b11000;
         end else begin
            p  = (k - 1) / PER;
            ph = (k - 1) % PER;
            s  = p / 33;
            j  = p % 33;
            o[4] = 1'b1;
            o[2] = (ph >= DIV);
            if (p == 132 || j == 0) o[1] = 1'b1;
            else                    o[0] = m_tx[s][32 - j];
         end
      end
      return o;
   endfunction

   // rx[s] takes the slave word once pulse 33*s+32 has finished
   function automatic logic [31:0] m_rx(input int s, input int k);
      if (m_valid && k >= (33 * s + 33) * PER + 1) return m_slave[s];
      return m_base[s];
   endfunction

   // Slave: the correct bit is only valid in the last low cycle of a data pulse
   function automatic logic slave_bit(input int k);
      int p, ph, s, j;
      if (m_valid && k >= 1 && k <= FRAME) begin
         p  = (k - 1) / PER;
         ph = (k - 1) % PER;
         s  = p / 33;
         j  = p % 33;
         if (p < 132 && j != 0) begin
            if (ph == DIV - 1) return m_slave[s][j - 1];
            return ~m_slave[s][j - 1];
         end
      end
      return 1'(edge_cnt & 1);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_board);
      #1;
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      for (int s = 0; s < 4; s++) begin
         m_tx[s]   = 32'd0;
         m_base[s] = 32'd0;
      end
   endtask

   // One input cycle; the model applies the write before the start
   task automatic cycle_in(input bit st, input bit we, input logic [1:0] sl,
                           input logic [31:0] d);
      int k;
      k = cur_k();
      start   = st;
      wr_en   = we;
      wr_slot = sl;
      wr_data = d;
      if (!m_busy(k)) begin
         if (we) m_tx[sl] = d;
         if (st) begin
            for (int s = 0; s < 4; s++) m_base[s] = m_rx(s, k);
            for (int s = 0; s < 4; s++) m_slave[s] = next_slave[s];
            m_base_edge = edge_cnt + 1;
            m_valid     = 1'b1;
         end
      end
      tick();
      start = 1'b0;
      wr_en = 1'b0;
   endtask

   task automatic wait_k(input int target);
      while (cur_k() < target) tick();
   endtask

   task automatic wait_done(output int e);
      int n;
      n = 0;
      e = -1;
      while (n < 3 * FRAME) begin
         tick();
         n++;
         if (done === 1'b1) begin
            e = edge_cnt;
            break;
         end
      end
      if (e < 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL done_timeout at %0t: got no done expected done within %0d cycles",
                  $time, 3 * FRAME);
      end
   endtask

   task automatic check_rd(input string name, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
      logic [31:0] e [4];
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      for (int s = 0; s < 4; s++) begin
         rd_slot = 2'(s);
         #1;
         check(name, rd_data, e[s]);
      end
      rd_slot = 2'd2;
   endtask

   // Slave driver
   initial begin
      dataoutbit = 1'b0;
      forever begin
         @(posedge clk_board);
         #1;
         dataoutbit = slave_bit(cur_k());
      end
   end

   // Compare process: every cycle against the model
   initial begin
      int k;
      forever begin
         @(negedge clk_board);
         k = cur_k();
         check("link_outputs", {27'd0, busy, done, clk_data, data_sync_en, datainbit},
               {27'd0, m_out(k)});
         check("rd_data_model", rd_data, m_rx(int'(rd_slot), k));
      end
   end

   // Pulse/done counters for frame-level literal checks
   int   rise_cnt = 0;
   int   sync_cnt = 0;
   int   done_cnt = 0;
   logic prev_clk = 1'b0;
   initial begin
      forever begin
         @(negedge clk_board);
         if (clk_data === 1'b1 && prev_clk === 1'b0) begin
            rise_cnt++;
            if (data_sync_en === 1'b1) sync_cnt++;
         end
         if (done === 1'b1) done_cnt++;
         prev_clk = clk_data;
      end
   end

   initial begin
      int r0, s0, d0, busy_edge, e;
      sys_reset_n = 1'b0;
      start = 1'b0;
      wr_en = 1'b0;
      wr_slot = 2'd0;
      wr_data = 32'd0;
      rd_slot = 2'd0;
      model_reset();
      repeat (3) tick();
      check("reset_outputs", {27'd0, busy, done, clk_data, data_sync_en, datainbit}, 32'd0);
      check_rd("reset_rd_data", 32'd0, 32'd0, 32'd0, 32'd0);
      sys_reset_n = 1'b1;
      repeat (4) tick();
      check("no_spontaneous_start", {31'd0, busy}, 32'd0);

      // Frame 1: datainbit pattern, done latency, rx capture; start+write same cycle
      cycle_in(1'b0, 1'b1, 2'd0, 32'h8000_0001);
      cycle_in(1'b0, 1'b1, 2'd1, 32'h1234_5678);
      cycle_in(1'b0, 1'b1, 2'd2, 32'h0000_0000);
      next_slave[0] = 32'h1357_9BDF;
      next_slave[1] = 32'h2468_ACE0;
      next_slave[2] = 32'hDEAD_BEEF;
      next_slave[3] = 32'h8000_0001;
      r0 = rise_cnt;
      s0 = sync_cnt;
      cycle_in(1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF);
      busy_edge = edge_cnt;
      check("f1_busy_rise", {31'd0, busy}, 32'd1);
      check("f1_first_sync", {31'd0, data_sync_en}, 32'd1);
      wait_k(PER + 1);
      check("f1_slot0_bit31", {31'd0, datainbit}, 32'd1);
      wait_k(2 * PER + 1);
      check("f1_slot0_bit30", {31'd0, datainbit}, 32'd0);
      wait_k(32 * PER + 1);
      check("f1_slot0_bit0", {31'd0, datainbit}, 32'd1);
      wait_k(33 * PER + 1);
      check("f1_slot1_sync", {31'd0, data_sync_en}, 32'd1);
      wait_done(e);
      check("f1_done_latency", 32'(e - busy_edge), 32'd798);
      check("f1_busy_in_done", {31'd0, busy}, 32'd1);
      tick();
      check("f1_after_done", {30'd0, busy, done}, 32'd0);
      check("f1_pulse_count", 32'(rise_cnt - r0), 32'd133);
      check("f1_sync_count", 32'(sync_cnt - s0), 32'd5);
      check_rd("f1_rd_data", 32'h1357_9BDF, 32'h2468_ACE0, 32'hDEAD_BEEF, 32'h8000_0001);

      // Frame 2: write and second start mid-frame are ignored
      next_slave[0] = 32'hC0FF_EE00;
      next_slave[1] = 32'h0000_0001;
      next_slave[2] = 32'h7FFF_FFFF;
      next_slave[3] = 32'hDEAD_BEEF;
      d0 = done_cnt;
      cycle_in(1'b1, 1'b0, 2'd0, 32'd0);
      wait_k(100);
      cycle_in(1'b0, 1'b1, 2'd0, 32'hAAAA_AAAA);
      wait_k(500);
      cycle_in(1'b1, 1'b0, 2'd0, 32'd0);
      wait_done(e);
      repeat (3) tick();
      check("f2_single_done", 32'(done_cnt - d0), 32'd1);
      check_rd("f2_rd_data", 32'hC0FF_EE00, 32'h0000_0001, 32'h7FFF_FFFF, 32'hDEAD_BEEF);

      // Frame 3: tx[0] kept its old value; reset lands in slot 1 shift
      next_slave[0] = 32'h0F0F_0F0F;
      next_slave[1] = 32'hF0F0_F0F0;
      next_slave[2] = 32'h1111_1111;
      next_slave[3] = 32'h2222_2222;
      cycle_in(1'b1, 1'b0, 2'd0, 32'd0);
      wait_k(PER + 1);
      check("f3_tx0_bit31", {31'd0, datainbit}, 32'd1);
      wait_k(3 * PER + 1);
      check("f3_tx0_bit29", {31'd0, datainbit}, 32'd0);
      wait_k(40 * PER + 2);
      sys_reset_n = 1'b0;
      model_reset();
      #1;
      check("midframe_reset_outputs",
            {27'd0, busy, done, clk_data, data_sync_en, datainbit}, 32'd0);
      check_rd("midframe_reset_rd", 32'd0, 32'd0, 32'd0, 32'd0);
      repeat (2) tick();
      sys_reset_n = 1'b1;
      repeat (4) tick();
      check("post_reset_idle", {31'd0, busy}, 32'd0);

      // Frame 4: clean frame after reset
      cycle_in(1'b0, 1'b1, 2'd0, 32'h0000_FFFF);
      cycle_in(1'b0, 1'b1, 2'd1, 32'hA5A5_A5A5);
      cycle_in(1'b0, 1'b1, 2'd2, 32'h0123_4567);
      cycle_in(1'b0, 1'b1, 2'd3, 32'h7654_3210);
      next_slave[0] = 32'hFEDC_BA98;
      next_slave[1] = 32'h0000_0000;
      next_slave[2] = 32'hFFFF_FFFF;
      next_slave[3] = 32'h55AA_55AA;
      r0 = rise_cnt;
      s0 = sync_cnt;
      cycle_in(1'b1, 1'b0, 2'd0, 32'd0);
      wait_k(PER + 1);
      check("f4_tx0_bit31", {31'd0, datainbit}, 32'd0);
      wait_done(e);
      tick();
      check("f4_pulse_count", 32'(rise_cnt - r0), 32'd133);
      check("f4_sync_count", 32'(sync_cnt - s0), 32'd5);
      check_rd("f4_rd_data", 32'hFEDC_BA98, 32'h0000_0000, 32'hFFFF_FFFF, 32'h55AA_55AA);

      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
